// File: rtl/bin_to_bcd4d_seq_pkg.sv
// Shared types and constants for the sequential 14-bit binary to 4-digit BCD converter.
package bin_to_bcd4d_seq_pkg;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;
    localparam int SR_W   = 4 * DIGITS + BIN_W;

    localparam logic [BIN_W-1:0] BCD_MAX = 14'd9999;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/bin_to_bcd4d_seq_if.sv
// Handshake and result bundle between a requester and the BCD converter.
interface bin_to_bcd4d_seq_if;
    import bin_to_bcd4d_seq_pkg::*;

    logic             start;
    logic [BIN_W-1:0] bin;
    logic             busy;
    logic             done;
    logic             ovf;
    bcd_digit_t       d1000;
    bcd_digit_t       d0100;
    bcd_digit_t       d0010;
    bcd_digit_t       d0001;

    modport master (
        output start, bin,
        input  busy, done, ovf, d1000, d0100, d0010, d0001
    );

    modport slave (
        input  start, bin,
        output busy, done, ovf, d1000, d0100, d0010, d0001
    );

endinterface

// File: rtl/bin_to_bcd4d_seq_add3.sv
// Double-dabble correction for one BCD nibble: values of 5 or more get 3 added before the shift.
module bcd_add3
    import bin_to_bcd4d_seq_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd4d_seq.sv
// Iterative shift-add-3 converter: one 14-bit value in, four BCD digits out after 16 cycles.
module bin_to_bcd4d_seq
    import bin_to_bcd4d_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    bin_to_bcd4d_seq_if.slave  bus
);

    state_t          state;
    logic [SR_W-1:0] sr;
    logic [SR_W-1:0] sr_adj;
    logic [3:0]      cnt;
    logic            ovf_flag;
    logic            busy_q;
    logic            done_q;
    logic            ovf_q;
    bcd_digit_t      d1000_q;
    bcd_digit_t      d0100_q;
    bcd_digit_t      d0010_q;
    bcd_digit_t      d0001_q;
    bcd_digit_t      adj [DIGITS];

    // Index 0 is the units nibble, sitting just above the binary field.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (sr[BIN_W + 4*g +: 4]),
            .dout (adj[g])
        );
    end

    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < DIGITS; i++) begin
            sr_adj[BIN_W + 4*i +: 4] = adj[i];
        end
    end

    // Outputs only move on the FINISH edge, so a new conversion never disturbs the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            ovf_flag <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            d1000_q  <= '0;
            d0100_q  <= '0;
            d0010_q  <= '0;
            d0001_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sr       <= {{(4*DIGITS){1'b0}}, bus.bin};
                        cnt      <= '0;
                        ovf_flag <= (bus.bin > BCD_MAX);
                        busy_q   <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= sr_adj << 1;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(BIN_W - 1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    if (ovf_flag) begin
                        d1000_q <= 4'd9;
                        d0100_q <= 4'd9;
                        d0010_q <= 4'd9;
                        d0001_q <= 4'd9;
                        ovf_q   <= 1'b1;
                    end else begin
                        d1000_q <= sr[BIN_W + 12 +: 4];
                        d0100_q <= sr[BIN_W + 8  +: 4];
                        d0010_q <= sr[BIN_W + 4  +: 4];
                        d0001_q <= sr[BIN_W      +: 4];
                        ovf_q   <= 1'b0;
                    end
                    cnt    <= '0;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.ovf   = ovf_q;
    assign bus.d1000 = d1000_q;
    assign bus.d0100 = d0100_q;
    assign bus.d0010 = d0010_q;
    assign bus.d0001 = d0001_q;

endmodule

// File: tb/tb_bin_to_bcd4d_seq.sv
// Self-checking bench for bin_to_bcd4d_seq: directed corner cases plus random values against an arithmetic model.
module tb_bin_to_bcd4d_seq;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    bin_to_bcd4d_seq_if bus();

    bin_to_bcd4d_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Returns {ovf, thousands, hundreds, tens, units} with digits packed as hex nibbles.
    function automatic logic [16:0] refModel(input int v);
        if (v > 9999) return {1'b1, 16'h9999};
        return {1'b0, 4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] digitsNow();
        return {bus.d1000, bus.d0100, bus.d0010, bus.d0001};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for the DONE pulse; cycles counts negedges sampled before DONE was seen.
    task automatic waitDone(output int cycles, output int busyCnt);
        cycles  = 0;
        busyCnt = 0;
        while (!bus.done && cycles < 40) begin
            busyCnt += int'(bus.busy);
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic applyStimulus(input int v, input string tag);
        logic [16:0] exp;
        int          lat;
        int          busyCnt;
        exp = refModel(v);
        @(negedge clk);
        bus.bin   = 14'(v);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(lat, busyCnt);
        checkOutput({tag, "_latency"}, 32'(lat), 32'd15);
        checkOutput({tag, "_busycycles"}, 32'(busyCnt), 32'd15);
        checkOutput({tag, "_digits"}, 32'(digitsNow()), 32'(exp[15:0]));
        checkOutput({tag, "_ovf"}, 32'(bus.ovf), 32'(exp[16]));
        checkOutput({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int          lat;
        int          busyCnt;
        int          doneSeen;
        logic [16:0] exp;

        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.bin    = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_ovf", 32'(bus.ovf), 32'd0);
        checkOutput("reset_digits", 32'(digitsNow()), 32'd0);
        rst_n = 1'b1;

        applyStimulus(1234, "bin1234");
        applyStimulus(0, "bin0");
        applyStimulus(9999, "bin9999");
        applyStimulus(9, "bin9");
        applyStimulus(10000, "bin10000");
        applyStimulus(16383, "bin16383");
        applyStimulus(42, "bin42");

        // START held high: back-to-back conversions, BIN changes mid-flight must not leak in.
        @(negedge clk);
        bus.bin   = 14'd5678;
        bus.start = 1'b1;
        @(negedge clk);
        repeat (5) @(negedge clk);
        bus.bin = 14'd1;
        checkOutput("hold_digits_midconv", 32'(digitsNow()), 32'h0042);
        waitDone(lat, busyCnt);
        checkOutput("stream_first_digits", 32'(digitsNow()), 32'h5678);
        bus.bin = 14'd5678;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            waitDone(lat, busyCnt);
            checkOutput("stream_period", 32'(lat + 1), 32'd16);
            checkOutput("stream_digits", 32'(digitsNow()), 32'h5678);
            checkOutput("stream_ovf", 32'(bus.ovf), 32'd0);
        end
        bus.start = 1'b0;
        lat = 0;
        while ((bus.busy || bus.done) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("stream_drain", 32'(bus.busy | bus.done), 32'd0);

        // START pulse while busy is ignored and does not queue a second conversion.
        @(negedge clk);
        bus.bin   = 14'd2468;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.bin   = 14'd1111;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(lat, busyCnt);
        checkOutput("ignore_latency", 32'(lat + 5), 32'd15);
        checkOutput("ignore_digits", 32'(digitsNow()), 32'h2468);
        doneSeen = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            doneSeen += int'(bus.done);
        end
        checkOutput("ignore_no_extra_done", 32'(doneSeen), 32'd0);

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        bus.bin   = 14'd4321;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_digits", 32'(digitsNow()), 32'd0);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        doneSeen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            doneSeen += int'(bus.done);
        end
        checkOutput("abort_no_done", 32'(doneSeen), 32'd0);
        applyStimulus(4321, "bin4321_after_reset");

        for (int i = 0; i < 300; i++) begin
            applyStimulus(int'($urandom_range(16383, 0)), "random");
        end

        exp = refModel(9998);
        applyStimulus(9998, "bin9998");
        checkOutput("bin9998_model", 32'(digitsNow()), 32'(exp[15:0]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
